draw_arbiter: RTL
=================

# draw_arbiter

Shares the single VGA adapter plot port (x, y, colour, plot) among several drawing clients: brick eraser, paddle drawer/eraser, ball drawer/eraser. Each client requests a solid rectangle fill. The block picks one pending request round-robin, latches its parameters, raster-scans the rectangle at one pixel per clock, then pulses done to the winning client. It sits between the game control FSM clients and vga_adapter, replacing direct client-to-adapter muxing.

## Interface
- NREQ, 3, number of requesters (index 0 = brick, 1 = paddle, 2 = ball)
- clk  in  1  system clock (CLOCK_50 at top level)
- reset  in  1  asynchronous, active-high reset
- req  in  NREQ  per-client request; hold high until own done
- req_x  in  NREQ*8  client i rectangle left x, bits [8i+7:8i]
- req_y  in  NREQ*7  client i top y, bits [7i+6:7i]
- req_w  in  NREQ*4  client i width minus one (1..16 pixels)
- req_h  in  NREQ*3  client i height minus one (1..8 pixels)
- req_colour  in  NREQ*3  client i fill colour
- grant  out  NREQ  one-hot; high for exactly one cycle when client i's job is latched
- done  out  NREQ  one-hot; high for exactly one cycle after client i's last pixel
- busy  out  1  high in every state except IDLE
- x  out  8  pixel x to vga_adapter (registered)
- y  out  7  pixel y to vga_adapter (registered)
- colour  out  3  pixel colour (registered)
- plot  out  1  pixel write strobe (registered)

## Operation
- States: IDLE, DRAW, DONE.
- IDLE: if any req is high, select a winner by round-robin. Search starts at index ptr+1 mod NREQ and takes the first high req.
  - Latch that client's x/y/w/h/colour. Set grant[winner]. Set ptr = winner. Go to DRAW.
  - No req high: stay in IDLE.
- DRAW: counters dx (0..w) and dy (0..h) scan row-major, dx fastest.
  - Each cycle, register x = x0+dx, y = y0+dy, colour = latched colour.
  - plot = 1 unless the pixel is clipped.
  - After pixel (w,h), go to DONE.
- Clipping: sums are computed 9-bit (x) and 8-bit (y), with no wrap. A pixel with x>159 or y>119 gives plot=0 but still consumes its cycle.
- DONE: plot=0, done[winner]=1 for the cycle. Next state is IDLE.
- Requester rules:
  - Deassert req on the edge that samples its done.
  - A req still high in IDLE is a new job.
  - Dropping req during DRAW is ignored; the job completes.
  - req_* inputs are don't-care after grant.
- Reset (async, any state):
  - State = IDLE, ptr = NREQ-1 (so client 0 has first priority).
  - x, y, colour, plot, grant, done, busy all 0. Counters 0.
  - An interrupted job is abandoned; no done is issued.

## Timing
- Edge E0 samples req in IDLE. grant is high during cycle E0–E1; busy rises at E0.
- Pixel k (k = 0..N-1, N = (w+1)(h+1)) appears on x/y/plot after edge E(k+1).
- done is high during cycle E(N+1)–E(N+2), and plot is 0 in that cycle.
- IDLE is entered at E(N+2); the earliest next grant edge is E(N+3).
- Job cost = N+3 cycles, edge to edge. Throughput ≤ 1 pixel/clk.
- The 16x8 maximum takes 128 pixel cycles plus 3.
- Outputs are glitch-free: all driven from flops.

## Test plan
- Single job:
  - Stimulus: req[1], x=10, y=20, w=1, h=1, colour=5.
  - Response: grant[1] once. Then plot=1 for exactly 4 cycles at (10,20), (11,20), (10,21), (11,21), colour 5. Then done[1] one cycle, busy low after.
- Simultaneous requests after reset:
  - Stimulus: all three req high; each client drops req on its done.
  - Response: grants in order 0, 1, 2. No pixel overlap. Each job separated by DONE and IDLE cycles.
- Round-robin fairness:
  - Stimulus: client 0 re-raises req immediately after its done while client 2 is pending.
  - Response: client 2 is granted before client 0's second job.
- Clipping:
  - Stimulus: x=158, y=119, w=3, h=1.
  - Response: 8 pixel cycles. plot=1 only at (158,119) and (159,119). done arrives on cycle 9 after grant.
- Maximum size:
  - Stimulus: 16x8 brick at (144,56).
  - Response: 128 plot cycles ending at (159,63), then done.
- Reset mid-DRAW:
  - Stimulus: assert reset at pixel 5 of a 4x4 job.
  - Response: all outputs 0 immediately, no done. After release, the same still-high req is re-granted from pixel (x0,y0).

Source files
------------

// File: rtl/draw_arbiter.sv
// Round-robin arbiter sharing the VGA plot port among rectangle-fill clients.
// The winning client's rectangle is raster-scanned at one pixel per clock, then done is pulsed.
module draw_arbiter #(
  parameter int unsigned NREQ = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*8-1:0] req_x,
  input  logic [NREQ*7-1:0] req_y,
  input  logic [NREQ*4-1:0] req_w,
  input  logic [NREQ*3-1:0] req_h,
  input  logic [NREQ*3-1:0] req_colour,
  output logic [NREQ-1:0]   grant,
  output logic [NREQ-1:0]   done,
  output logic              busy,
  output logic [7:0]        x,
  output logic [6:0]        y,
  output logic [2:0]        colour,
  output logic              plot
);

  localparam int unsigned     PW  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [NREQ-1:0] ONE = NREQ'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRAW,
    S_DONE
  } state_t;

  state_t          state_q;
  logic [PW-1:0]   ptr_q;
  logic [PW-1:0]   win_d;
  logic            win_vld_d;
  logic [7:0]      x0_q;
  logic [6:0]      y0_q;
  logic [3:0]      w_q;
  logic [2:0]      h_q;
  logic [2:0]      col_q;
  logic [3:0]      dx_q;
  logic [2:0]      dy_q;
  logic [8:0]      xs_d;
  logic [7:0]      ys_d;
  logic [NREQ-1:0] grant_q;
  logic [NREQ-1:0] done_q;
  logic            busy_q;
  logic [7:0]      x_q;
  logic [6:0]      y_q;
  logic [2:0]      colour_q;
  logic            plot_q;

  // Round-robin search starting just after the last winner.
  always_comb begin
    win_d     = ptr_q;
    win_vld_d = 1'b0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      if (!win_vld_d && req[(32'(ptr_q) + k) % NREQ]) begin
        win_vld_d = 1'b1;
        win_d     = PW'((32'(ptr_q) + k) % NREQ);
      end
    end
  end

  // Widened sums so off-screen pixels are detected instead of wrapping.
  always_comb begin
    xs_d = {1'b0, x0_q} + 9'(dx_q);
    ys_d = {1'b0, y0_q} + 8'(dy_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      ptr_q    <= PW'(NREQ - 1);
      x0_q     <= '0;
      y0_q     <= '0;
      w_q      <= '0;
      h_q      <= '0;
      col_q    <= '0;
      dx_q     <= '0;
      dy_q     <= '0;
      grant_q  <= '0;
      done_q   <= '0;
      busy_q   <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      colour_q <= '0;
      plot_q   <= 1'b0;
    end else begin
      grant_q <= '0;
      case (state_q)
        S_IDLE: begin
          if (win_vld_d) begin
            ptr_q   <= win_d;
            grant_q <= ONE << win_d;
            x0_q    <= req_x[win_d*8 +: 8];
            y0_q    <= req_y[win_d*7 +: 7];
            w_q     <= req_w[win_d*4 +: 4];
            h_q     <= req_h[win_d*3 +: 3];
            col_q   <= req_colour[win_d*3 +: 3];
            dx_q    <= '0;
            dy_q    <= '0;
            busy_q  <= 1'b1;
            state_q <= S_DRAW;
          end
        end
        S_DRAW: begin
          x_q      <= xs_d[7:0];
          y_q      <= ys_d[6:0];
          colour_q <= col_q;
          plot_q   <= (xs_d <= 9'd159) && (ys_d <= 8'd119);
          if (dx_q == w_q) begin
            dx_q <= '0;
            if (dy_q == h_q) begin
              state_q <= S_DONE;
            end else begin
              dy_q <= dy_q + 3'd1;
            end
          end else begin
            dx_q <= dx_q + 4'd1;
          end
        end
        S_DONE: begin
          // Two cycles here: the last pixel stays visible, then done pulses with plot low.
          if (done_q == '0) begin
            plot_q <= 1'b0;
            done_q <= ONE << ptr_q;
          end else begin
            done_q  <= '0;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign grant  = grant_q;
  assign done   = done_q;
  assign busy   = busy_q;
  assign x      = x_q;
  assign y      = y_q;
  assign colour = colour_q;
  assign plot   = plot_q;

endmodule
